// File: rtl/wb_arb_mux_if.sv
// Bus bundle connecting the Wishbone masters and slaves to wb_arb_mux.
// The slave modport is the arbiter's view. The master modport is the view of the surrounding agents.
interface wb_arb_mux_if #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH  = 4,
    parameter int NUM_MASTERS   = 2,
    parameter int NUM_SLAVES    = 4
);
    logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0] m_addr_i;
    logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] m_data_i;
    logic [NUM_MASTERS*WB_SEL_WIDTH-1:0]  m_sel_i;
    logic [NUM_MASTERS-1:0]               m_we_i;
    logic [NUM_MASTERS-1:0]               m_stb_i;
    logic [NUM_MASTERS-1:0]               m_cyc_i;
    logic [NUM_MASTERS-1:0]               m_ack_o;
    logic [NUM_MASTERS-1:0]               m_err_o;
    logic [WB_DATA_WIDTH-1:0]             m_data_o;

    logic [WB_ADDR_WIDTH-1:0]             s_addr_o;
    logic [WB_DATA_WIDTH-1:0]             s_data_o;
    logic [WB_SEL_WIDTH-1:0]              s_sel_o;
    logic                                 s_we_o;
    logic [NUM_SLAVES-1:0]                s_stb_o;
    logic [NUM_SLAVES-1:0]                s_cyc_o;
    logic [NUM_SLAVES-1:0]                s_ack_i;
    logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]  s_data_i;

    modport slave (
        input  m_addr_i, m_data_i, m_sel_i, m_we_i, m_stb_i, m_cyc_i,
        input  s_ack_i, s_data_i,
        output m_ack_o, m_err_o, m_data_o,
        output s_addr_o, s_data_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o
    );

    modport master (
        output m_addr_i, m_data_i, m_sel_i, m_we_i, m_stb_i, m_cyc_i,
        output s_ack_i, s_data_i,
        input  m_ack_o, m_err_o, m_data_o,
        input  s_addr_o, s_data_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o
    );
endinterface

// File: rtl/wb_arb_mux.sv
// Round-robin Wishbone arbiter with a shared slave bus, address decoder, bus-error path and watchdog.
// A grant is held until the owner drops cyc. Decode misses and watchdog expiry each cost one ERROR cycle.
module wb_arb_mux #(
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_SEL_WIDTH   = 4,
    parameter int NUM_MASTERS    = 2,
    parameter int NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_MASK = '0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    wb_arb_mux_if.slave            bus,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic                   timeout_o
);
    localparam int AW  = WB_ADDR_WIDTH;
    localparam int DW  = WB_DATA_WIDTH;
    localparam int SW  = WB_SEL_WIDTH;
    localparam int MW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SIW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANTED,
        ST_ERROR
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          owner_q, owner_d;
    logic [MW-1:0]          last_q, last_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;

    logic [AW-1:0]          gnt_addr;
    logic [DW-1:0]          gnt_data;
    logic [SW-1:0]          gnt_sel;
    logic                   gnt_we, gnt_stb, gnt_cyc;

    logic                   hit_any;
    logic [SIW-1:0]         hit_idx;
    logic                   hit_ack;
    logic [DW-1:0]          hit_data;
    logic                   ack_fwd;

    logic                   pick_any;
    logic [MW-1:0]          pick_idx;
    int                     cand;

    // Mux of the owning master's request; the owner is meaningful in GRANTED and ERROR.
    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        gnt_sel  = '0;
        gnt_we   = 1'b0;
        gnt_stb  = 1'b0;
        gnt_cyc  = 1'b0;
        if (state_q != ST_IDLE) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (owner_q == MW'(i)) begin
                    gnt_addr = bus.m_addr_i[i*AW +: AW];
                    gnt_data = bus.m_data_i[i*DW +: DW];
                    gnt_sel  = bus.m_sel_i[i*SW +: SW];
                    gnt_we   = bus.m_we_i[i];
                    gnt_stb  = bus.m_stb_i[i];
                    gnt_cyc  = bus.m_cyc_i[i];
                end
            end
        end
    end

    // Descending scan so the lowest-numbered matching slave is the one left standing.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        hit_ack  = 1'b0;
        hit_data = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if ((gnt_addr & SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW]) begin
                hit_any = 1'b1;
                hit_idx = SIW'(k);
            end
        end
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (hit_any && hit_idx == SIW'(k)) begin
                hit_ack  = bus.s_ack_i[k];
                hit_data = bus.s_data_i[k*DW +: DW];
            end
        end
    end

    assign ack_fwd = (state_q == ST_GRANTED) && hit_any && hit_ack;

    always_comb begin
        bus.s_addr_o = gnt_addr;
        bus.s_data_o = gnt_data;
        bus.s_sel_o  = gnt_sel;
        bus.s_we_o   = gnt_we;
        bus.s_cyc_o  = '0;
        bus.s_stb_o  = '0;
        if (state_q == ST_GRANTED && hit_any) begin
            for (int k = 0; k < NUM_SLAVES; k++) begin
                if (hit_idx == SIW'(k)) begin
                    bus.s_cyc_o[k] = gnt_cyc;
                    bus.s_stb_o[k] = gnt_stb;
                end
            end
        end
        bus.m_data_o = (state_q != ST_IDLE && hit_any) ? hit_data : '0;
        bus.m_ack_o  = ack_fwd ? grant_q : '0;
        bus.m_err_o  = (state_q == ST_ERROR) ? grant_q : '0;
    end

    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;

    // Round-robin pick starting after the previous owner. The descending loop lets the nearest requester win.
    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            cand = int'(last_q) + 1 + i;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (bus.m_cyc_i[MW'(cand)]) begin
                pick_any = 1'b1;
                pick_idx = MW'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = '0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANTED;
                    owner_d = pick_idx;
                    grant_d = NUM_MASTERS'(1) << pick_idx;
                end
            end
            ST_GRANTED: begin
                if (!gnt_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end else if (gnt_stb && !hit_any) begin
                    state_d = ST_ERROR;
                end else if (gnt_stb && !ack_fwd && TIMEOUT_CYCLES != 0) begin
                    // This stalled cycle is the one that brings the count up to the limit.
                    if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = ST_ERROR;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                if (!gnt_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end else begin
                    state_d = ST_GRANTED;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            last_q    <= MW'(NUM_MASTERS - 1);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
endmodule

// File: doc/wb_arb_mux.md
WB_ARB_MUX -- requirements
Module: wb_arb_mux

Interface
REQ-001 SHALL have parameter WB_DATA_WIDTH, default 32, data bus width.
REQ-002 SHALL have parameter WB_ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter WB_SEL_WIDTH, default 4, byte-select width (WB_DATA_WIDTH/8).
REQ-004 SHALL have parameter NUM_MASTERS, default 2, number of masters, range 1..8.
REQ-005 SHALL have parameter NUM_SLAVES, default 4, number of slaves, range 1..16.
REQ-006 SHALL have parameter SLAVE_BASE, default 0, packed NUM_SLAVES*WB_ADDR_WIDTH, per-slave base address; slave k in bits [k*AW +: AW].
REQ-007 SHALL have parameter SLAVE_MASK, default 0, packed like SLAVE_BASE, per-slave decode mask.
REQ-008 SHALL have parameter TIMEOUT_CYCLES, default 255, bus watchdog limit; 0 disables.
REQ-009 clk_i  in  1  single clock; all logic on rising edge.
REQ-010 rst_i  in  1  reset, synchronous, active-low.
REQ-011 m_addr_i / m_data_i  in  NM*AW / NM*DW  packed master address / write data.
REQ-012 m_sel_i  in  NM*SW;  m_we_i, m_stb_i, m_cyc_i  in  NM  packed master controls.
REQ-013 m_ack_o, m_err_o  out  NM  per-master ack / bus-error.
REQ-014 m_data_o  out  DW  read data, shared by all masters.
REQ-015 s_addr_o, s_data_o, s_sel_o, s_we_o  out  AW/DW/SW/1  shared slave bus.
REQ-016 s_stb_o, s_cyc_o  out  NS  per-slave strobe / cycle.
REQ-017 s_ack_i  in  NS;  s_data_i  in  NS*DW  per-slave ack / read data.
REQ-018 grant_o  out  NM  one-hot current grant, all-zero when idle.
REQ-019 timeout_o  out  1  one-cycle pulse when the watchdog fires.

Function
REQ-020 FSM states SHALL be IDLE, GRANTED, ERROR.
REQ-021 IDLE: if any m_cyc_i high, SHALL register grant to the first requesting master searching round-robin from (last_grant+1) mod NM, enter GRANTED next cycle; else stay IDLE.
REQ-022 Arbitration latency SHALL be exactly 1 cycle: request seen at edge n -> grant_o and slave strobes valid after edge n+1.
REQ-023 GRANTED: grant SHALL be held while granted m_cyc_i is high; no preemption.
REQ-024 Granted m_cyc_i low SHALL clear grant and return to IDLE; last_grant updated; re-arbitration takes one IDLE cycle.
REQ-025 s_addr_o/s_data_o/s_sel_o/s_we_o SHALL combinationally mirror the granted master; all zero when idle.
REQ-026 Decode: slave k hit when (s_addr_o & MASK_k) == BASE_k; lowest k wins on multiple hits.
REQ-027 s_cyc_o[k] = granted cyc AND hit k; s_stb_o[k] = granted stb AND hit k; combinational.
REQ-028 m_ack_o[g] SHALL equal s_ack_i of the hit slave for granted g only (same-cycle path); non-granted acks 0.
REQ-029 m_data_o SHALL equal s_data_i of the hit slave; zero on no hit or idle.
REQ-030 GRANTED with stb high and no hit: SHALL drive no slave strobe, enter ERROR; ERROR lasts one cycle, asserts m_err_o[g], returns to GRANTED (or IDLE if cyc dropped).
REQ-031 Watchdog: counter (width clog2(TIMEOUT_CYCLES+1)) increments each GRANTED cycle with stb high and no ack; cleared on ack, stb low, or state change.
REQ-032 Counter reaching TIMEOUT_CYCLES SHALL enter ERROR (m_err_o pulse) and pulse timeout_o in that same ERROR cycle; counter cleared.
REQ-033 During ERROR all s_stb_o and s_cyc_o SHALL be 0; late s_ack_i ignored.
REQ-034 m_ack_o and m_err_o SHALL never be high together for any master.
REQ-035 NUM_MASTERS=1 SHALL degenerate to fixed grant with identical timing.

Reset
REQ-036 rst_i low at an edge SHALL force IDLE, grant_o=0, last_grant=NM-1 (master 0 wins next), counter=0, timeout_o=0.
REQ-037 Reset mid-transfer SHALL drop all s_stb_o/s_cyc_o and m_ack_o/m_err_o to 0 from the next cycle; no ack forwarded.

Verification
REQ-038 M0 and M1 cyc high same cycle after reset -> grant_o=01 after 1 edge; M0 drops cyc -> IDLE 1 cycle -> grant_o=10.
REQ-039 NS=2, BASE={0x0000_1000,0x8000_0000}, MASK={0xFFFF_F000,0xF000_0000}; read 0x8000_0010 -> s_stb_o=10, slave1 data 0xDEADBEEF on m_data_o with ack same cycle.
REQ-040 Access to 0x4000_0000 (no hit) -> s_stb_o=00, m_err_o[g] one-cycle pulse next cycle, no ack.
REQ-041 TIMEOUT_CYCLES=4, slave never acks -> m_err_o and timeout_o pulse together exactly once after 4 stalled cycles.
REQ-042 rst_i low during a stalled transfer -> all strobes/grants 0 next cycle; after release, M0 granted first.
